// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns pc_f, drives the instruction-memory request and buffers redirects.
// Optional macro PC_RANGE_CHECK_EN adds an [IM_LO, IM_HI] range check to the AdEL flag.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_d,
    input  logic [31:0] npc,
    input  logic        d_is_jump,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        im_ready,
    output logic [31:0] pc_f,
    output logic        im_req,
    output logic        f_valid,
    output logic        bd_f,
    output logic        adel_f
);

    // im_req/im_ready: a request is outstanding while im_req is high and completes on the
    // cycle im_ready is also high; pc_f (the address) is held stable until that cycle.
    typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pend, pend_nxt, pc_nxt, target;
    logic        bd_nxt, redir, done;

    assign redir  = exc_req | eret_req;
    assign target = exc_req ? EXC_ENTRY : epc;

`ifdef PC_RANGE_CHECK_EN
    assign adel_f = (pc_f[1:0] != 2'b00) | (pc_f < IM_LO) | (pc_f > IM_HI);
`else
    assign adel_f = (pc_f[1:0] != 2'b00);
`endif

    // A faulting address is never put on the bus; it completes at once so the AdEL flows down.
    assign im_req  = (state != BOOT) & !adel_f;
    assign done    = adel_f | (im_req & im_ready);
    assign f_valid = (state == FETCH) & done & !stall_d & !redir;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_f;
        pend_nxt  = pend;
        bd_nxt    = bd_f;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
                if (redir) pc_nxt = target;
            end
            FETCH: begin
                if (redir && done) begin
                    pc_nxt = target;
                    bd_nxt = 1'b0;
                end else if (redir) begin
                    pend_nxt  = target;
                    state_nxt = REDIR_WAIT;
                end else if (done && !stall_d) begin
                    pc_nxt = npc;
                    bd_nxt = d_is_jump;
                end
            end
            REDIR_WAIT: begin
                if (done) begin
                    pc_nxt    = redir ? target : pend;
                    bd_nxt    = 1'b0;
                    state_nxt = FETCH;
                end else if (redir) begin
                    pend_nxt = target;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_f  <= RESET_PC;
            pend  <= 32'h0;
            bd_f  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_f  <= pc_nxt;
            pend  <= pend_nxt;
            bd_f  <= bd_nxt;
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage PC sequencer for the pipelined MIPS core. It owns the F-stage PC register and drives the instruction-memory request with a valid/ready handshake. It selects between the NPC block's `next_pc`, exception entry and ERET return, and holds the PC under hazard stalls. It also buffers redirects that arrive while a fetch is outstanding and flags delay-slot and address-error conditions for the F-stage instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC loaded on reset.
- `EXC_ENTRY`, 32'h0000_4180: exception handler entry.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IM_HI`, 32'h0000_6FFC: highest legal fetch address.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `stall_d`, in, 1: hazard stall; F must hold its PC.
- `npc`, in, 32: NPC `next_pc` for the current `pc_f`.
- `d_is_jump`, in, 1: D-stage instruction is a branch, j or jr, so the next fetched word is a delay slot.
- `exc_req`, in, 1: CP0 exception taken.
- `eret_req`, in, 1: ERET executed.
- `epc`, in, 32: ERET return address.
- `im_ready`, in, 1: instruction memory completes the request this cycle.
- `pc_f`, out, 32: F-stage PC; also the memory address.
- `im_req`, out, 1: fetch request valid.
- `f_valid`, out, 1: the F instruction is accepted into D this cycle.
- `bd_f`, out, 1: F instruction is a delay slot.
- `adel_f`, out, 1: F-stage address error (AdEL).

## Operation
- Redirect:
  - `redir = exc_req | eret_req`.
  - Target is `EXC_ENTRY` when `exc_req` is set, else `epc`; `exc_req` wins if both are set.
- `adel_f = (pc_f[1:0] != 0)`, plus the range check when configured.
- While `adel_f` is set:
  - `im_req` is forced to 0.
  - Internal completion `done = 1`.
  - Otherwise `done = im_req & im_ready`.
- FSM states: BOOT, FETCH, REDIR_WAIT.
- BOOT:
  - `im_req` = 0.
  - Moves unconditionally to FETCH on the next edge.
  - A redirect in BOOT loads its target into `pc_f`.
- FETCH, `im_req` = !`adel_f`, checked in priority order:
  - `redir & done`: `pc_f`<=target, `bd_f`<=0, `f_valid`=0 (squash).
  - `redir & !done`: `pend`<=target, go to REDIR_WAIT.
  - `done & !stall_d`: `pc_f`<=`npc`, `bd_f`<=`d_is_jump`, `f_valid`=1.
  - `done & stall_d`: hold `pc_f`; same address re-requested next cycle; `f_valid`=0.
  - Otherwise hold.
- REDIR_WAIT:
  - `im_req` stays 1 and `pc_f` stays unchanged (bus address must stay stable until ready).
  - `f_valid`=0 and `stall_d` is ignored.
  - A further redirect overwrites `pend` with the same priority rule.
  - On `done`: `pc_f`<=`pend`, or that cycle's redirect target if one is present; `bd_f`<=0; go to FETCH.
- `f_valid` is combinational and equals `state==FETCH & done & !stall_d & !redir`.
- All PC arithmetic is done in NPC; this block only muxes and registers. `pend` is 32 bits.

## Timing
- Reset values:
  - `pc_f`=`RESET_PC`, state=BOOT, `pend`=0.
  - `bd_f`=0, `im_req`=0, `f_valid`=0.
  - `adel_f` is set only by `RESET_PC` itself, which is 0 for the default.
- Reset asserted mid-fetch drops the outstanding request immediately and asynchronously; no completion is owed.
- First request: the cycle after reset release plus one (BOOT lasts one cycle).
- Zero-wait memory gives one fetch per cycle: `pc_f` updates on the edge after `done`.
- Redirect latency:
  - One edge when it coincides with `done`.
  - Otherwise the edge after the eventual `im_ready`.
- `im_req` never drops while a request is unacknowledged, except on reset.

## Configuration
- `PC_RANGE_CHECK_EN`:
  - Defined: `adel_f` also asserts when `pc_f < IM_LO` or `pc_f > IM_HI`.
  - Undefined: only misalignment raises `adel_f`, and any aligned address is fetched.

## Test plan
- Reset release with `im_ready`=1 and `npc`=`pc_f`+4 -> `im_req` low for 1 cycle; then `pc_f` runs 0x3000, 0x3004, 0x3008 with `f_valid`=1 each cycle.
- `stall_d`=1 for 3 cycles at `pc_f`=0x3008 -> `pc_f` holds 0x3008, `f_valid`=0 for those cycles, then resumes at 0x300C.
- `d_is_jump`=1 when advancing 0x3010->0x3014 -> `bd_f`=1 for the 0x3014 fetch; `bd_f` clears on the next plain advance.
- `exc_req`=1 while `im_ready`=0 for 2 cycles at 0x3020 -> address stays 0x3020 until ready, `f_valid`=0, then `pc_f`=0x4180. An `eret_req` arriving in the wait with `epc`=0x3040 is overridden only if `exc_req` is also present, else `pc_f`=0x3040.
- Simultaneous `exc_req` and `eret_req` with `im_ready`=1 -> `pc_f`=0x4180 and `f_valid`=0.
- `npc`=0x3002 -> `adel_f`=1, `im_req`=0, `f_valid`=1. With `PC_RANGE_CHECK_EN` defined, `npc`=0x7000 also raises `adel_f`; without it, `npc`=0x7000 issues a normal request.
